// File: rtl/acc_bank_seq_ctrl_if.sv
// Handshake and bank-control bundle between an accumulator bank sequencer and its array/bank/PPU side.
// ACC_SEQ_PERF_EN adds the perf_stall_cnt field to both modports.
interface acc_bank_seq_ctrl_if #(
   parameter int KT_W   = 8,
   parameter int PERF_W = 16
);
   logic              start;
   logic [3:0]        cfg_rows;
   logic [KT_W-1:0]   cfg_k_tiles;
   logic              psum_valid;
   logic              psum_ready;
   logic [3:0]        bank_addr;
   logic              bank_wr_en;
   logic              bank_acc_mode;
   logic              drain_valid;
   logic              drain_ready;
   logic              drain_last;
   logic              busy;
   logic              done;
`ifdef ACC_SEQ_PERF_EN
   logic [PERF_W-1:0] perf_stall_cnt;

   modport master (
      output start, cfg_rows, cfg_k_tiles, psum_valid, drain_ready,
      input  psum_ready, bank_addr, bank_wr_en, bank_acc_mode,
             drain_valid, drain_last, busy, done, perf_stall_cnt
   );
   modport slave (
      input  start, cfg_rows, cfg_k_tiles, psum_valid, drain_ready,
      output psum_ready, bank_addr, bank_wr_en, bank_acc_mode,
             drain_valid, drain_last, busy, done, perf_stall_cnt
   );
`else
   modport master (
      output start, cfg_rows, cfg_k_tiles, psum_valid, drain_ready,
      input  psum_ready, bank_addr, bank_wr_en, bank_acc_mode,
             drain_valid, drain_last, busy, done
   );
   modport slave (
      input  start, cfg_rows, cfg_k_tiles, psum_valid, drain_ready,
      output psum_ready, bank_addr, bank_wr_en, bank_acc_mode,
             drain_valid, drain_last, busy, done
   );
`endif
endinterface

// File: rtl/acc_bank_seq_ctrl.sv
// Accumulator column-bank sequencer: steers psum rows into the bank (overwrite then accumulate), then drains to the PPU.
// Zero-latency write/drain strobes; drain stalls hold addr/valid/last. ACC_SEQ_PERF_EN adds a saturating stall counter.
module acc_bank_seq_ctrl #(
   parameter int MAX_ROWS = 12,
   parameter int KT_W     = 8,
   parameter int PERF_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   acc_bank_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      row_cnt;
   logic [KT_W-1:0] k_cnt;
   // Job shape is kept as last-index values so a full 16-row bank still fits 4 bits.
   logic [3:0]      last_row_q;
   logic [KT_W-1:0] last_k_q;
   logic [3:0]      last_row_cfg;
   logic [KT_W-1:0] last_k_cfg;
   logic            start_fire;
   logic            psum_fire;
   logic            drain_fire;
   logic            row_end;

   always_comb begin
      last_row_cfg = bus.cfg_rows - 4'd1;
      if (bus.cfg_rows == 4'd0 || 32'(bus.cfg_rows) > MAX_ROWS)
         last_row_cfg = 4'(MAX_ROWS - 1);
      last_k_cfg = bus.cfg_k_tiles - 1'b1;
      if (bus.cfg_k_tiles == '0)
         last_k_cfg = '0;
   end

   assign row_end       = (row_cnt == last_row_q);
   assign bus.bank_addr = row_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      start_fire        = 1'b0;
      psum_fire         = 1'b0;
      drain_fire        = 1'b0;
      bus.psum_ready    = 1'b0;
      bus.bank_wr_en    = 1'b0;
      bus.bank_acc_mode = 1'b0;
      bus.drain_valid   = 1'b0;
      bus.drain_last    = 1'b0;
      bus.busy          = 1'b1;
      bus.done          = 1'b0;
      case (state)
         S_IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               start_fire = 1'b1;
               state_nxt  = S_ACC;
            end
         end
         S_ACC: begin
            bus.psum_ready    = 1'b1;
            psum_fire         = bus.psum_valid;
            bus.bank_wr_en    = bus.psum_valid;
            bus.bank_acc_mode = (k_cnt != '0);
            if (psum_fire && row_end && k_cnt == last_k_q)
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            bus.drain_valid = 1'b1;
            bus.drain_last  = row_end;
            drain_fire      = bus.drain_ready;
            if (drain_fire && row_end)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt    <= '0;
         k_cnt      <= '0;
         last_row_q <= '0;
         last_k_q   <= '0;
      end else begin
         if (start_fire) begin
            last_row_q <= last_row_cfg;
            last_k_q   <= last_k_cfg;
            row_cnt    <= '0;
            k_cnt      <= '0;
         end
         if (psum_fire) begin
            if (row_end) begin
               row_cnt <= '0;
               k_cnt   <= (k_cnt == last_k_q) ? '0 : k_cnt + 1'b1;
            end else begin
               row_cnt <= row_cnt + 4'd1;
            end
         end
         if (drain_fire)
            row_cnt <= row_end ? 4'd0 : row_cnt + 4'd1;
      end
   end

`ifdef ACC_SEQ_PERF_EN
   logic stall;
   assign stall = (state == S_ACC && !bus.psum_valid) || (state == S_DRAIN && !bus.drain_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.perf_stall_cnt <= '0;
      else if (start_fire)
         bus.perf_stall_cnt <= '0;
      else if (stall && !(&bus.perf_stall_cnt))
         bus.perf_stall_cnt <= bus.perf_stall_cnt + 1'b1;
   end
`endif
endmodule
